soc_boot_sequencer: RTL



---
 rtl/soc_boot_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/soc_boot_sequencer.sv
// ============================================================================
// Module   : soc_boot_sequencer
// Purpose  : Reset stretcher and processor-enable sequencer for mor1k_16Soc,
//            with soft-reset request and debug run/halt control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_boot_sequencer #(
    parameter int RST_CYCLES = 20,
    parameter int EN_DELAY   = 8,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       soft_reset_req,
    input  logic       debug_halt,
    output logic       soc_reset,
    output logic       processors_en,
    output logic       seq_done,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_EN_LAST  = CNT_W'(EN_DELAY - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               soc_reset_q;
    logic               proc_en_q;
    logic               seq_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            soc_reset_q <= 1'b1;
            proc_en_q   <= 1'b0;
            seq_done_q  <= 1'b0;
        end else if (soft_reset_req) begin
            // Held request parks the FSM in HOLD with the count frozen at zero
            state_q     <= HOLD;
            cnt_q       <= '0;
            soc_reset_q <= 1'b1;
            proc_en_q   <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == C_RST_LAST) begin
                        state_q     <= WAIT;
                        cnt_q       <= '0;
                        soc_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == C_EN_LAST) begin
                        seq_done_q <= 1'b1;
                        state_q    <= debug_halt ? HALT : RUN;
                        proc_en_q  <= ~debug_halt;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (debug_halt) begin
                        state_q   <= HALT;
                        proc_en_q <= 1'b0;
                    end
                end
                HALT: begin
                    // Cores are frozen here, never reset
                    if (!debug_halt) begin
                        state_q   <= RUN;
                        proc_en_q <= 1'b1;
                    end
                end
                default: state_q <= HOLD;
            endcase
        end
    end

    assign soc_reset     = soc_reset_q;
    assign processors_en = proc_en_q;
    assign seq_done      = seq_done_q;
    assign state_o       = state_q;

endmodule

`default_nettype wire
